// File: rtl/ram_lvt_pkg.sv
// Shared definitions for the live-value-table multi-port RAM.
package ram_lvt_pkg;

   // Widest bank index an LVT entry can carry; supports up to 256 write ports.
   localparam int unsigned LVT_BANK_MAX = 8;

   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      int unsigned v;
      r = 0;
      v = 1;
      while (v < n) begin
         v = v << 1;
         r = r + 1;
      end
      return r;
   endfunction

   function automatic int unsigned lvt_width(input int unsigned nw);
      return (clog2(nw) > 1) ? clog2(nw) : 1;
   endfunction

   typedef struct packed {
      logic                    live;
      logic [LVT_BANK_MAX-1:0] bank;
   } lvt_entry_t;

endpackage

// File: rtl/ram_nr1w.sv
// Single-write, multi-read storage bank; reads are combinational, array has no reset.
module ram_nr1w #(
   parameter int unsigned DW = 32,
   parameter int unsigned AW = 10,
   parameter int unsigned NR = 4
) (
   input  logic              clk,
   input  logic              w_enb,
   input  logic [AW-1:0]     w_addr,
   input  logic [DW-1:0]     w_din,
   input  logic [NR*AW-1:0]  r_addr,
   output logic [NR*DW-1:0]  r_data
);

   logic [DW-1:0] mem [2**AW];

   always_ff @(posedge clk) begin
      if (w_enb) begin
         mem[w_addr] <= w_din;
      end
   end

   always_comb begin
      r_data = '0;
      for (int unsigned k = 0; k < NR; k++) begin
         r_data[k*DW +: DW] = mem[r_addr[k*AW +: AW]];
      end
   end

endmodule

// File: rtl/ram_lvt_mrnw.sv
// NR-read / NW-write RAM: one bank per write port, a live value table picks the newest bank.
module ram_lvt_mrnw
   import ram_lvt_pkg::*;
#(
   parameter int unsigned DW        = 32,
   parameter int unsigned AW        = 10,
   parameter int unsigned NR        = 4,
   parameter int unsigned NW        = 8,
   parameter bit          WR_BYPASS = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NW-1:0]     w_enb,
   input  logic [NW*AW-1:0]  w_addr,
   input  logic [NW*DW-1:0]  w_din,
   input  logic [NR-1:0]     r_enb,
   input  logic [NR*AW-1:0]  r_addr,
   output logic [NR*DW-1:0]  r_dout,
   output logic [NR-1:0]     r_valid,
   output logic              w_conflict
);

   localparam int unsigned DEPTH = 2**AW;
   localparam int unsigned LVTW  = lvt_width(NW);

   logic [DEPTH-1:0] live;
   logic [LVTW-1:0]  lvt_bank [DEPTH];
   logic [NR*DW-1:0] bank_rdata [NW];
   logic [NR*DW-1:0] rd_next;
   logic             conflict;

   for (genvar b = 0; b < NW; b++) begin : g_bank
      ram_nr1w #(
         .DW (DW),
         .AW (AW),
         .NR (NR)
      ) u_bank (
         .clk    (clk),
         .w_enb  (w_enb[b]),
         .w_addr (w_addr[b*AW +: AW]),
         .w_din  (w_din[b*DW +: DW]),
         .r_addr (r_addr),
         .r_data (bank_rdata[b])
      );
   end

   // Only the live bits are reset; they mask whatever the banks and bank indices hold.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         live <= '0;
      end else begin
         for (int unsigned b = 0; b < NW; b++) begin
            if (w_enb[b]) begin
               live[w_addr[b*AW +: AW]] <= 1'b1;
            end
         end
      end
   end

   // Ascending loop: the last (highest-index) enabled port on an address owns the entry.
   always_ff @(posedge clk) begin
      for (int unsigned b = 0; b < NW; b++) begin
         if (w_enb[b]) begin
            lvt_bank[w_addr[b*AW +: AW]] <= LVTW'(b);
         end
      end
   end

   always_comb begin
      logic [AW-1:0] addr;
      lvt_entry_t    entry;
      logic [DW-1:0] word;
      addr    = '0;
      entry   = '0;
      word    = '0;
      rd_next = '0;
      for (int unsigned k = 0; k < NR; k++) begin
         addr       = r_addr[k*AW +: AW];
         entry.live = live[addr];
         entry.bank = LVT_BANK_MAX'(lvt_bank[addr]);
         word       = '0;
         if (entry.live) begin
            for (int unsigned b = 0; b < NW; b++) begin
               if (entry.bank == LVT_BANK_MAX'(b)) begin
                  word = bank_rdata[b][k*DW +: DW];
               end
            end
         end
         if (WR_BYPASS) begin
            for (int unsigned b = 0; b < NW; b++) begin
               if (w_enb[b] && (w_addr[b*AW +: AW] == addr)) begin
                  word = w_din[b*DW +: DW];
               end
            end
         end
         rd_next[k*DW +: DW] = word;
      end
   end

   always_comb begin
      conflict = 1'b0;
      for (int unsigned i = 0; i < NW; i++) begin
         for (int unsigned j = i + 1; j < NW; j++) begin
            if (w_enb[i] && w_enb[j] && (w_addr[i*AW +: AW] == w_addr[j*AW +: AW])) begin
               conflict = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_dout     <= '0;
         r_valid    <= '0;
         w_conflict <= 1'b0;
      end else begin
         for (int unsigned k = 0; k < NR; k++) begin
            r_valid[k] <= r_enb[k];
            if (r_enb[k]) begin
               r_dout[k*DW +: DW] <= rd_next[k*DW +: DW];
            end
         end
         w_conflict <= conflict;
      end
   end

endmodule

// File: tb/tb_ram_lvt_mrnw.sv
// Directed bench for ram_lvt_mrnw: read-first and write-first instances share one stimulus.
module tb_ram_lvt_mrnw;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 10;
   localparam int unsigned NR = 4;
   localparam int unsigned NW = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic [NW-1:0]     w_enb;
   logic [NW*AW-1:0]  w_addr;
   logic [NW*DW-1:0]  w_din;
   logic [NR-1:0]     r_enb;
   logic [NR*AW-1:0]  r_addr;
   logic [NR*DW-1:0]  r_dout0, r_dout1;
   logic [NR-1:0]     r_valid0, r_valid1;
   logic              w_conflict0, w_conflict1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ram_lvt_mrnw #(.DW(DW), .AW(AW), .NR(NR), .NW(NW), .WR_BYPASS(1'b0)) dut0 (
      .clk(clk), .rst(rst), .w_enb(w_enb), .w_addr(w_addr), .w_din(w_din),
      .r_enb(r_enb), .r_addr(r_addr), .r_dout(r_dout0), .r_valid(r_valid0),
      .w_conflict(w_conflict0)
   );

   ram_lvt_mrnw #(.DW(DW), .AW(AW), .NR(NR), .NW(NW), .WR_BYPASS(1'b1)) dut1 (
      .clk(clk), .rst(rst), .w_enb(w_enb), .w_addr(w_addr), .w_din(w_din),
      .r_enb(r_enb), .r_addr(r_addr), .r_dout(r_dout1), .r_valid(r_valid1),
      .w_conflict(w_conflict1)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      w_enb  = '0;
      w_addr = '0;
      w_din  = '0;
      r_enb  = '0;
      r_addr = '0;
   endtask

   task automatic set_write(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
      w_enb[p]            = 1'b1;
      w_addr[p*AW +: AW]  = a;
      w_din[p*DW +: DW]   = d;
   endtask

   task automatic set_read(input int p, input logic [AW-1:0] a);
      r_enb[p]            = 1'b1;
      r_addr[p*AW +: AW]  = a;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      clear_inputs();
      r_enb = '1;
      step();
      step();
      checks++; if (r_valid0 !== 4'b0000) begin errors++; $display("FAIL reset_valid0 got %b exp 0000", r_valid0); end
      checks++; if (r_valid1 !== 4'b0000) begin errors++; $display("FAIL reset_valid1 got %b exp 0000", r_valid1); end
      checks++; if (r_dout0 !== 128'h0) begin errors++; $display("FAIL reset_dout0 got %h exp 0", r_dout0); end
      checks++; if (r_dout1 !== 128'h0) begin errors++; $display("FAIL reset_dout1 got %h exp 0", r_dout1); end
      checks++; if (w_conflict0 !== 1'b0 || w_conflict1 !== 1'b0) begin errors++; $display("FAIL reset_conflict got %b%b exp 00", w_conflict0, w_conflict1); end
      rst = 1'b1;
      clear_inputs();
      set_read(0, 10'd0); set_read(1, 10'd5); set_read(2, 10'd1023); set_read(3, 10'd5);
      step();
      checks++; if (r_valid0 !== 4'b1111 || r_dout0 !== 128'h0) begin errors++; $display("FAIL empty_read_a0 got %b %h exp 1111 0", r_valid0, r_dout0); end
      checks++; if (r_valid1 !== 4'b1111 || r_dout1 !== 128'h0) begin errors++; $display("FAIL empty_read_a1 got %b %h exp 1111 0", r_valid1, r_dout1); end
      clear_inputs();
      set_read(0, 10'd1023); set_read(1, 10'd0); set_read(2, 10'd5); set_read(3, 10'd1023);
      step();
      checks++; if (r_valid0 !== 4'b1111 || r_dout0 !== 128'h0) begin errors++; $display("FAIL empty_read_b0 got %b %h exp 1111 0", r_valid0, r_dout0); end
      checks++; if (r_valid1 !== 4'b1111 || r_dout1 !== 128'h0) begin errors++; $display("FAIL empty_read_b1 got %b %h exp 1111 0", r_valid1, r_dout1); end
   endtask

   task automatic test_single_write();
      clear_inputs();
      set_write(3, 10'd7, 32'hDEADBEEF);
      step();
      checks++; if (r_valid0 !== 4'b0000) begin errors++; $display("FAIL idle_valid got %b exp 0000", r_valid0); end
      clear_inputs();
      set_read(0, 10'd7);
      step();
      checks++; if (r_dout0[0 +: DW] !== 32'hDEADBEEF) begin errors++; $display("FAIL single_wr0 got %h exp deadbeef", r_dout0[0 +: DW]); end
      checks++; if (r_dout1[0 +: DW] !== 32'hDEADBEEF) begin errors++; $display("FAIL single_wr1 got %h exp deadbeef", r_dout1[0 +: DW]); end
      checks++; if (r_valid0 !== 4'b0001) begin errors++; $display("FAIL single_valid got %b exp 0001", r_valid0); end
      checks++; if (r_dout0[DW +: DW] !== 32'h0) begin errors++; $display("FAIL single_hold got %h exp 0", r_dout0[DW +: DW]); end
   endtask

   task automatic test_conflict();
      clear_inputs();
      set_write(1, 10'd20, 32'h11);
      set_write(4, 10'd20, 32'h44);
      set_write(6, 10'd20, 32'h66);
      step();
      checks++; if (w_conflict0 !== 1'b1 || w_conflict1 !== 1'b1) begin errors++; $display("FAIL conflict_set got %b%b exp 11", w_conflict0, w_conflict1); end
      clear_inputs();
      set_read(2, 10'd20);
      step();
      checks++; if (w_conflict0 !== 1'b0 || w_conflict1 !== 1'b0) begin errors++; $display("FAIL conflict_clear got %b%b exp 00", w_conflict0, w_conflict1); end
      checks++; if (r_dout0[2*DW +: DW] !== 32'h66) begin errors++; $display("FAIL conflict_win0 got %h exp 66", r_dout0[2*DW +: DW]); end
      checks++; if (r_dout1[2*DW +: DW] !== 32'h66) begin errors++; $display("FAIL conflict_win1 got %h exp 66", r_dout1[2*DW +: DW]); end
      clear_inputs();
      set_write(0, 10'd40, 32'h1);
      set_write(1, 10'd41, 32'h2);
      step();
      checks++; if (w_conflict0 !== 1'b0) begin errors++; $display("FAIL no_conflict got %b exp 0", w_conflict0); end
      clear_inputs();
      set_read(0, 10'd40);
      set_read(1, 10'd41);
      step();
      checks++; if (r_dout0[0 +: DW] !== 32'h1 || r_dout0[DW +: DW] !== 32'h2) begin errors++; $display("FAIL dual_write got %h %h exp 1 2", r_dout0[0 +: DW], r_dout0[DW +: DW]); end
   endtask

   task automatic test_read_during_write();
      clear_inputs();
      set_write(2, 10'd9, 32'hA);
      step();
      clear_inputs();
      set_write(5, 10'd9, 32'hB);
      set_read(1, 10'd9);
      step();
      checks++; if (r_dout0[DW +: DW] !== 32'hA) begin errors++; $display("FAIL rdw_readfirst got %h exp a", r_dout0[DW +: DW]); end
      checks++; if (r_dout1[DW +: DW] !== 32'hB) begin errors++; $display("FAIL rdw_writefirst got %h exp b", r_dout1[DW +: DW]); end
      clear_inputs();
      set_read(1, 10'd9);
      step();
      checks++; if (r_dout0[DW +: DW] !== 32'hB || r_dout1[DW +: DW] !== 32'hB) begin errors++; $display("FAIL rdw_after got %h %h exp b b", r_dout0[DW +: DW], r_dout1[DW +: DW]); end
      clear_inputs();
      set_write(2, 10'd9, 32'hC);
      set_write(6, 10'd9, 32'hD);
      set_read(1, 10'd9);
      step();
      checks++; if (r_dout0[DW +: DW] !== 32'hB) begin errors++; $display("FAIL rdw_multi_rf got %h exp b", r_dout0[DW +: DW]); end
      checks++; if (r_dout1[DW +: DW] !== 32'hD) begin errors++; $display("FAIL rdw_multi_wf got %h exp d", r_dout1[DW +: DW]); end
      checks++; if (w_conflict1 !== 1'b1) begin errors++; $display("FAIL rdw_conflict got %b exp 1", w_conflict1); end
   endtask

   task automatic test_back_to_back();
      clear_inputs();
      set_write(0, 10'd30, 32'h5);
      step();
      clear_inputs();
      set_write(7, 10'd30, 32'h6);
      set_read(3, 10'd30);
      step();
      checks++; if (r_dout0[3*DW +: DW] !== 32'h5) begin errors++; $display("FAIL b2b_1_rf got %h exp 5", r_dout0[3*DW +: DW]); end
      checks++; if (r_dout1[3*DW +: DW] !== 32'h6) begin errors++; $display("FAIL b2b_1_wf got %h exp 6", r_dout1[3*DW +: DW]); end
      clear_inputs();
      set_write(0, 10'd30, 32'h7);
      set_read(3, 10'd30);
      step();
      checks++; if (r_dout0[3*DW +: DW] !== 32'h6) begin errors++; $display("FAIL b2b_2_rf got %h exp 6", r_dout0[3*DW +: DW]); end
      checks++; if (r_dout1[3*DW +: DW] !== 32'h7) begin errors++; $display("FAIL b2b_2_wf got %h exp 7", r_dout1[3*DW +: DW]); end
      clear_inputs();
      set_read(3, 10'd30);
      step();
      checks++; if (r_dout0[3*DW +: DW] !== 32'h7 || r_dout1[3*DW +: DW] !== 32'h7) begin errors++; $display("FAIL b2b_3 got %h %h exp 7 7", r_dout0[3*DW +: DW], r_dout1[3*DW +: DW]); end
      clear_inputs();
      step();
      checks++; if (r_valid0 !== 4'b0000 || r_valid1 !== 4'b0000) begin errors++; $display("FAIL hold_valid got %b %b exp 0000", r_valid0, r_valid1); end
      checks++; if (r_dout0[3*DW +: DW] !== 32'h7) begin errors++; $display("FAIL hold_data got %h exp 7", r_dout0[3*DW +: DW]); end
   endtask

   task automatic test_reset_mid();
      clear_inputs();
      set_write(4, 10'd2, 32'h99);
      step();
      clear_inputs();
      set_read(0, 10'd2);
      step();
      checks++; if (r_dout0[0 +: DW] !== 32'h99) begin errors++; $display("FAIL pre_reset got %h exp 99", r_dout0[0 +: DW]); end
      #1 rst = 1'b0;
      #1;
      checks++; if (r_dout0 !== 128'h0 || r_valid0 !== 4'b0000) begin errors++; $display("FAIL mid_reset0 got %h %b exp 0 0000", r_dout0, r_valid0); end
      checks++; if (r_dout1 !== 128'h0 || r_valid1 !== 4'b0000) begin errors++; $display("FAIL mid_reset1 got %h %b exp 0 0000", r_dout1, r_valid1); end
      #1 rst = 1'b1;
      clear_inputs();
      set_read(0, 10'd2);
      step();
      checks++; if (r_dout0[0 +: DW] !== 32'h0 || r_valid0[0] !== 1'b1) begin errors++; $display("FAIL post_reset got %h %b exp 0 1", r_dout0[0 +: DW], r_valid0[0]); end
      rst = 1'b0;
      clear_inputs();
      set_write(5, 10'd3, 32'h33);
      step();
      step();
      rst = 1'b1;
      clear_inputs();
      set_read(0, 10'd3);
      step();
      checks++; if (r_dout0[0 +: DW] !== 32'h0 || r_dout1[0 +: DW] !== 32'h0) begin errors++; $display("FAIL write_in_reset got %h %h exp 0 0", r_dout0[0 +: DW], r_dout1[0 +: DW]); end
      clear_inputs();
      set_write(6, 10'd2, 32'h77);
      step();
      clear_inputs();
      set_read(0, 10'd2);
      step();
      checks++; if (r_dout0[0 +: DW] !== 32'h77 || r_dout1[0 +: DW] !== 32'h77) begin errors++; $display("FAIL after_release got %h %h exp 77 77", r_dout0[0 +: DW], r_dout1[0 +: DW]); end
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_conflict();
      test_read_during_write();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
